// File: rtl/ir_prefetch_queue_if.sv
// rtl/ir_prefetch_queue_if.sv - fetch/issue/instruction bundle between sequencers and the prefetch queue
interface ir_prefetch_queue_if #(
  parameter int INST_WIDTH = 12,
  parameter int DEPTH      = 2
);
  localparam int CW = $clog2(DEPTH + 1);

  logic                  fetch_valid;
  logic [INST_WIDTH-1:0] fetch_data;
  logic                  fetch_ready;
  logic                  issue;
  logic                  skip;
  logic                  goto;
  logic [INST_WIDTH-1:0] ir;
  logic                  ir_valid;
  logic [CW-1:0]         count;
  logic                  overflow;

  modport master (
    output fetch_valid, fetch_data, issue, skip, goto,
    input  fetch_ready, ir, ir_valid, count, overflow
  );

  modport slave (
    input  fetch_valid, fetch_data, issue, skip, goto,
    output fetch_ready, ir, ir_valid, count, overflow
  );
endinterface

// File: rtl/ir_prefetch_queue.sv
// rtl/ir_prefetch_queue.sv - DEPTH-entry prefetch FIFO with registered instruction output and skip/goto kill
module ir_prefetch_queue #(
  parameter int                    INST_WIDTH = 12,
  parameter int                    DEPTH      = 2,
  parameter logic [INST_WIDTH-1:0] NOP_CODE   = '0
) (
  input logic               clk,
  input logic               rst,
  ir_prefetch_queue_if.slave bus
);
  localparam int                CW       = $clog2(DEPTH + 1);
  localparam int                PW       = $clog2(DEPTH);
  localparam logic [CW-1:0]     FULL_CNT = CW'(DEPTH);

  logic [INST_WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [INST_WIDTH-1:0] ir_q, ir_d;
  logic                  ir_valid_q, ir_valid_d;
  logic                  overflow_q, overflow_d;
  logic                  skip_pending_q, skip_pending_d;
  logic                  push, pop, flush;
  logic                  have_head, full;
  logic [INST_WIDTH-1:0] head;

  assign have_head = (count_q != '0);
  assign full      = (count_q == FULL_CNT);
  assign head      = mem_q[rd_ptr_q];

  always_comb begin
    ir_d           = ir_q;
    ir_valid_d     = ir_valid_q;
    overflow_d     = overflow_q;
    skip_pending_d = skip_pending_q;
    push           = 1'b0;
    pop            = 1'b0;
    flush          = 1'b0;

    if (bus.issue && bus.goto) begin
      ir_d           = NOP_CODE;
      ir_valid_d     = 1'b0;
      skip_pending_d = 1'b0;
      flush          = 1'b1;
    end else if (bus.issue && bus.skip) begin
      ir_d       = NOP_CODE;
      ir_valid_d = 1'b0;
      // Kill the oldest candidate: head, then the word on the bus, else defer.
      if (have_head) begin
        pop  = 1'b1;
        push = bus.fetch_valid;
      end else if (!bus.fetch_valid) begin
        skip_pending_d = 1'b1;
      end
    end else if (bus.issue) begin
      if (have_head) begin
        ir_d       = head;
        ir_valid_d = 1'b1;
        pop        = 1'b1;
        push       = bus.fetch_valid;
      end else if (bus.fetch_valid && !skip_pending_q) begin
        ir_d       = bus.fetch_data;
        ir_valid_d = 1'b1;
      end else begin
        ir_d       = NOP_CODE;
        ir_valid_d = 1'b0;
        if (bus.fetch_valid) begin
          skip_pending_d = 1'b0;
        end
      end
    end else if (bus.fetch_valid) begin
      if (skip_pending_q) begin
        skip_pending_d = 1'b0;
      end else if (!full) begin
        push = 1'b1;
      end else begin
        overflow_d = 1'b1;
      end
    end

    if (flush) begin
      count_d  = '0;
      rd_ptr_d = wr_ptr_q;
      wr_ptr_d = wr_ptr_q;
    end else begin
      count_d  = count_q + CW'(push) - CW'(pop);
      rd_ptr_d = rd_ptr_q + PW'(pop);
      wr_ptr_d = wr_ptr_q + PW'(push);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q       <= '0;
      wr_ptr_q       <= '0;
      count_q        <= '0;
      ir_q           <= NOP_CODE;
      ir_valid_q     <= 1'b0;
      overflow_q     <= 1'b0;
      skip_pending_q <= 1'b0;
    end else begin
      rd_ptr_q       <= rd_ptr_d;
      wr_ptr_q       <= wr_ptr_d;
      count_q        <= count_d;
      ir_q           <= ir_d;
      ir_valid_q     <= ir_valid_d;
      overflow_q     <= overflow_d;
      skip_pending_q <= skip_pending_d;
    end
  end

  // Storage is not reset; count and pointers alone decide what is live.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem_q[wr_ptr_q] <= bus.fetch_data;
    end
  end

  assign bus.fetch_ready = !full;
  assign bus.ir          = ir_q;
  assign bus.ir_valid    = ir_valid_q;
  assign bus.count       = count_q;
  assign bus.overflow    = overflow_q;
endmodule

// File: tb/tb_ir_prefetch_queue.sv
// tb/tb_ir_prefetch_queue.sv - directed and randomized checks of ir_prefetch_queue at DEPTH 2 and 4
module tb_ir_prefetch_queue;
  logic        clk;
  logic        rst_i;
  logic        fv_i;
  logic [11:0] fd_i;
  logic        iss_i, sk_i, gt_i;

  int n_checks;
  int n_pass;

  ir_prefetch_queue_if #(.INST_WIDTH(12), .DEPTH(2)) bus2 ();
  ir_prefetch_queue_if #(.INST_WIDTH(12), .DEPTH(4)) bus4 ();

  assign bus2.fetch_valid = fv_i;
  assign bus2.fetch_data  = fd_i;
  assign bus2.issue       = iss_i;
  assign bus2.skip        = sk_i;
  assign bus2.goto        = gt_i;
  assign bus4.fetch_valid = fv_i;
  assign bus4.fetch_data  = fd_i;
  assign bus4.issue       = iss_i;
  assign bus4.skip        = sk_i;
  assign bus4.goto        = gt_i;

  ir_prefetch_queue #(.INST_WIDTH(12), .DEPTH(2), .NOP_CODE(12'h000)) u_dut2 (
    .clk(clk), .rst(rst_i), .bus(bus2)
  );
  ir_prefetch_queue #(.INST_WIDTH(12), .DEPTH(4), .NOP_CODE(12'h000)) u_dut4 (
    .clk(clk), .rst(rst_i), .bus(bus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a plain queue per depth plus the visible registers.
  logic [11:0] mq [2][$];
  logic [11:0] m_ir   [2];
  logic        m_irv  [2];
  logic        m_ovf  [2];
  logic        m_pend [2];
  int          m_depth[2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic model_step(input int m);
    logic [11:0] w;
    if (rst_i) begin
      mq[m].delete();
      m_ir[m] = 12'h000; m_irv[m] = 1'b0; m_ovf[m] = 1'b0; m_pend[m] = 1'b0;
    end else if (iss_i && gt_i) begin
      mq[m].delete();
      m_ir[m] = 12'h000; m_irv[m] = 1'b0; m_pend[m] = 1'b0;
    end else if (iss_i && sk_i) begin
      m_ir[m] = 12'h000; m_irv[m] = 1'b0;
      if (mq[m].size() > 0) begin
        w = mq[m].pop_front();
        if (fv_i) mq[m].push_back(fd_i);
      end else if (!fv_i) begin
        m_pend[m] = 1'b1;
      end
    end else if (iss_i) begin
      if (mq[m].size() > 0) begin
        m_ir[m] = mq[m].pop_front(); m_irv[m] = 1'b1;
        if (fv_i) mq[m].push_back(fd_i);
      end else if (fv_i && !m_pend[m]) begin
        m_ir[m] = fd_i; m_irv[m] = 1'b1;
      end else begin
        m_ir[m] = 12'h000; m_irv[m] = 1'b0;
        if (fv_i) m_pend[m] = 1'b0;
      end
    end else if (fv_i) begin
      if (m_pend[m]) m_pend[m] = 1'b0;
      else if (mq[m].size() < m_depth[m]) mq[m].push_back(fd_i);
      else m_ovf[m] = 1'b1;
    end
  endtask

  task automatic compare_all();
    check("d2_ir",    32'(bus2.ir),          32'(m_ir[0]));
    check("d2_irv",   32'(bus2.ir_valid),    32'(m_irv[0]));
    check("d2_count", 32'(bus2.count),       32'(mq[0].size()));
    check("d2_ready", 32'(bus2.fetch_ready), 32'(mq[0].size() < m_depth[0]));
    check("d2_ovf",   32'(bus2.overflow),    32'(m_ovf[0]));
    check("d4_ir",    32'(bus4.ir),          32'(m_ir[1]));
    check("d4_irv",   32'(bus4.ir_valid),    32'(m_irv[1]));
    check("d4_count", 32'(bus4.count),       32'(mq[1].size()));
    check("d4_ready", 32'(bus4.fetch_ready), 32'(mq[1].size() < m_depth[1]));
    check("d4_ovf",   32'(bus4.overflow),    32'(m_ovf[1]));
  endtask

  task automatic cyc(input logic r, input logic fv, input logic [11:0] fd,
                     input logic is, input logic sk, input logic gt);
    @(negedge clk);
    rst_i = r; fv_i = fv; fd_i = fd; iss_i = is; sk_i = sk; gt_i = gt;
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    compare_all();
  endtask

  task automatic push(input logic [11:0] w);
    cyc(1'b0, 1'b1, w, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_issue();
    cyc(1'b0, 1'b0, 12'h000, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    n_checks = 0; n_pass = 0;
    m_depth[0] = 2; m_depth[1] = 4;
    rst_i = 1'b1; fv_i = 1'b0; fd_i = '0; iss_i = 1'b0; sk_i = 1'b0; gt_i = 1'b0;

    // Reset and idle
    cyc(1'b1, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 12'hA05, 1'b0, 1'b0, 1'b0);
    check("rst_ir",    32'(bus2.ir), 32'h000);
    check("rst_irv",   32'(bus2.ir_valid), 0);
    check("rst_count", 32'(bus2.count), 0);
    check("rst_ready", 32'(bus2.fetch_ready), 1);
    check("rst_ovf",   32'(bus2.overflow), 0);

    // Fill and in-order issue
    push(12'h111); push(12'h222);
    check("fill_count", 32'(bus2.count), 2);
    check("fill_ready", 32'(bus2.fetch_ready), 0);
    do_issue(); check("iss1_ir", 32'(bus2.ir), 32'h111); check("iss1_irv", 32'(bus2.ir_valid), 1);
    do_issue(); check("iss2_ir", 32'(bus2.ir), 32'h222); check("iss2_count", 32'(bus2.count), 0);
    do_issue(); check("bubble_ir", 32'(bus2.ir), 32'h000); check("bubble_irv", 32'(bus2.ir_valid), 0);

    // Overflow
    push(12'h111); push(12'h222); push(12'h333);
    check("ovf_flag",  32'(bus2.overflow), 1);
    check("ovf_count", 32'(bus2.count), 2);
    do_issue(); check("ovf_ir1", 32'(bus2.ir), 32'h111);
    do_issue(); check("ovf_ir2", 32'(bus2.ir), 32'h222);
    do_issue(); check("ovf_ir3", 32'(bus2.ir_valid), 0);
    check("ovf_sticky", 32'(bus2.overflow), 1);
    cyc(1'b1, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0);
    check("ovf_cleared", 32'(bus2.overflow), 0);

    // Skip with a queued head, then skip on empty deferred to the next fetch
    push(12'h111); push(12'h222);
    cyc(1'b0, 1'b0, 12'h000, 1'b1, 1'b1, 1'b0);
    check("skip_ir", 32'(bus2.ir), 32'h000);
    check("skip_irv", 32'(bus2.ir_valid), 0);
    check("skip_count", 32'(bus2.count), 1);
    do_issue(); check("skip_next", 32'(bus2.ir), 32'h222);
    cyc(1'b0, 1'b0, 12'h000, 1'b1, 1'b1, 1'b0);
    push(12'h444); check("pend_eat", 32'(bus2.count), 0);
    push(12'h555);
    do_issue(); check("pend_next", 32'(bus2.ir), 32'h555);

    // Goto flush beats skip and drops the same-cycle fetch
    push(12'h111); push(12'h222);
    cyc(1'b0, 1'b1, 12'h666, 1'b1, 1'b1, 1'b1);
    check("goto_ir", 32'(bus2.ir), 32'h000);
    check("goto_count", 32'(bus2.count), 0);
    check("goto_ovf", 32'(bus2.overflow), 0);
    push(12'h777);
    do_issue(); check("goto_next", 32'(bus2.ir), 32'h777);

    // Bypass then steady push+issue across pointer wrap
    cyc(1'b0, 1'b1, 12'h001, 1'b1, 1'b0, 1'b0);
    check("wrap_1", 32'(bus4.ir), 32'h001);
    push(12'h002);
    for (int i = 3; i <= 10; i++) begin
      cyc(1'b0, 1'b1, 12'(i), 1'b1, 1'b0, 1'b0);
      check("wrap_ir", 32'(bus4.ir), 32'(i - 1));
      check("wrap_irv", 32'(bus4.ir_valid), 1);
    end
    do_issue(); check("wrap_10", 32'(bus4.ir), 32'h00A);

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      cyc(($urandom_range(0, 99) == 0),
          ($urandom_range(0, 9) < 6),
          12'($urandom),
          ($urandom_range(0, 1) == 1),
          ($urandom_range(0, 5) == 0),
          ($urandom_range(0, 9) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/ir_prefetch_queue.md
Name: ir_prefetch_queue

Overview:
- Parametrised successor to the single-entry instruction register: a DEPTH-entry prefetch FIFO feeding a registered current-instruction output.
- Sits between the program memory read path and the instruction decoder. The fetch sequencer pushes words; the execute sequencer issues them.
- Adds a selective kill. A skip kills one instruction; a goto flushes the whole prefetch stream. Both replace the issued instruction with NOP.

Parameters:
INST_WIDTH, 12, instruction word width in bits
DEPTH, 2, prefetch FIFO entries; power of two, >= 2
NOP_CODE, 12'h000, encoding loaded into ir on kill, bubble and reset (INST_WIDTH bits)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous reset, active-high
fetch_valid  input  1  program memory word valid this cycle (fetch Q4 strobe)
fetch_data  input  INST_WIDTH  program memory word
fetch_ready  output  1  FIFO not full (count < DEPTH), combinational from state
issue  input  1  execute-side advance strobe (execute Q1)
skip  input  1  kill next instruction; sampled only when issue=1
goto  input  1  flush prefetch stream; sampled only when issue=1
ir  output  INST_WIDTH  current instruction, registered
ir_valid  output  1  ir holds a real fetched instruction (0 for NOP from kill, bubble or reset)
count  output  clog2(DEPTH+1)  FIFO occupancy
overflow  output  1  sticky: a fetch was dropped while full

Behaviour:
Reset (rst=1 at a clock edge, overrides everything):
- ir=NOP_CODE, ir_valid=0, count=0, pointers=0, overflow=0, skip_pending=0.
- A mid-operation reset discards FIFO contents. A fetch or issue in the same cycle is ignored.

FIFO:
- Circular buffer with rd/wr pointers that wrap modulo DEPTH.
- count = writes minus reads and never exceeds DEPTH.
- A pushed word is visible at the head the next cycle.

Per-cycle priority when rst=0:
1. issue=1 & goto=1:
   - ir<=NOP_CODE, ir_valid<=0.
   - FIFO cleared (count<=0, rd_ptr<=wr_ptr).
   - skip_pending<=0.
   - A same-cycle fetch_valid word is dropped; overflow is not set.
   - goto wins over a simultaneous skip.
2. issue=1 & skip=1, goto=0:
   - ir<=NOP_CODE, ir_valid<=0.
   - Exactly one instruction is discarded, taken in this order:
     - the FIFO head (pop), if count>0;
     - otherwise the same-cycle fetch_data, which is not enqueued;
     - otherwise set skip_pending<=1, so the next accepted fetch word is discarded instead of enqueued, then skip_pending clears.
   - If count>0, a same-cycle fetch pushes normally.
3. issue=1, no kill:
   - count>0: ir<=head, ir_valid<=1, pop. A same-cycle fetch pushes, and push+pop at full is legal.
   - count=0 and fetch_valid=1 (bypass): ir<=fetch_data, ir_valid<=1. The word is not enqueued unless skip_pending=1, in which case the word is discarded, the bubble rule applies and skip_pending clears.
   - count=0, no fetch: bubble, ir<=NOP_CODE, ir_valid<=0.
4. issue=0:
   - ir and ir_valid hold.
   - skip and goto are ignored.
   - fetch_valid pushes if count<DEPTH, or is consumed by skip_pending.
   - fetch_valid with count=DEPTH and no pop: word dropped, overflow<=1 and held until rst.

Latency:
- ir reflects the issue-cycle decision one cycle later; there is no combinational path from input to ir.

Test Plan:
- Reset then idle: after rst, ir=12'h000, ir_valid=0, count=0, fetch_ready=1, overflow=0. Hold rst during fetch_valid=1 with 12'hA05 and confirm count remains 0.
- Fill and in-order issue: push 12'h111 then 12'h222 (count=2, fetch_ready=0). Issue twice; ir=12'h111 then 12'h222, ir_valid=1, count returns to 0. A third issue gives ir=12'h000, ir_valid=0.
- Overflow: with count=2, fetch 12'h333 with no issue. Expect overflow=1, count=2, and later issues return 12'h111, 12'h222 only. overflow stays 1 until rst.
- Skip: queue 12'h111, 12'h222, then issue with skip=1. Expect ir=12'h000, ir_valid=0, count=1. Next issue gives ir=12'h222. Repeat with an empty FIFO and no fetch, then fetch 12'h444 followed by 12'h555. Expect 12'h444 discarded via skip_pending and the next issue gives 12'h555.
- Goto flush: queue 12'h111, 12'h222, then issue with goto=1, skip=1 and fetch_valid=1 with 12'h666. Expect ir=12'h000, count=0, overflow=0. A subsequent fetch of 12'h777 is issued next.
- Bypass and wrap: with DEPTH=4, run 10 push/issue pairs of the values 12'h001..12'h00A, including same-cycle push+issue on an empty FIFO. Expect ir sequence 12'h001..12'h00A in order, correct across pointer wrap, with no bubbles.
